// File: rtl/fifo_dest_if.sv
// Handshake and status bundle between one destination-demux output and its FIFO.
// The consumer side (master) drives data and strobes; the FIFO (slave) returns data and flags.
interface fifo_dest_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] datain;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] dataout;
  logic              valid_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              fifo_error;

  modport master (
    output datain, push, pop,
    input  dataout, valid_out, fifo_full, fifo_empty,
    input  almost_full, almost_empty, count, fifo_error
  );

  modport slave (
    input  datain, push, pop,
    output dataout, valid_out, fifo_full, fifo_empty,
    output almost_full, almost_empty, count, fifo_error
  );
endinterface

// File: rtl/fifo_dest.sv
// Circular-buffer FIFO behind one destination-demux output, with a registered read port,
// occupancy/threshold flags and a sticky overflow/underflow error.
module fifo_dest #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AF_THR = 3,
  parameter int AE_THR = 1
) (
  input logic        clk,
  input logic        reset_L,
  fifo_dest_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF_THR = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] C_AE_THR = CNT_W'(AE_THR);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dataout;
  logic              r_valid;
  logic              r_error;

  logic w_not_empty;
  logic w_pop_acc;
  logic w_push_acc;
  logic w_err_evt;

  // A push into a full FIFO is still taken when a pop frees a slot on the same edge;
  // the pop never bypasses an empty FIFO, so an empty push+pop is push-only.
  always_comb begin
    w_not_empty = (r_count != '0);
    w_pop_acc   = bus.pop && w_not_empty;
    w_push_acc  = bus.push && ((r_count < C_DEPTH) || w_pop_acc);
    w_err_evt   = (bus.push && !w_push_acc) || (bus.pop && !w_not_empty);
  end

  always_ff @(posedge clk) begin
    if (w_push_acc && reset_L) begin
      r_mem[r_wr_ptr] <= bus.datain;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dataout <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_valid <= w_pop_acc;
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_acc) begin
        r_dataout <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_err_evt) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.dataout      = r_dataout;
  assign bus.valid_out    = r_valid;
  assign bus.count        = r_count;
  assign bus.fifo_error   = r_error;
  assign bus.fifo_full    = (r_count == C_DEPTH);
  assign bus.fifo_empty   = (r_count == '0);
  assign bus.almost_full  = (r_count >= C_AF_THR);
  assign bus.almost_empty = (r_count <= C_AE_THR);
endmodule

// File: tb/tb_fifo_dest.sv
// Self-checking bench for fifo_dest: a behavioural occupancy model plus a queue of
// expected read words that is compared whenever the DUT presents valid_out.
module tb_fifo_dest;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset_L;

  fifo_dest_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_dest #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THR(3), .AE_THR(1)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] m_store [$];
  logic [DATA_W-1:0] exp_q   [$];
  logic [DATA_W-1:0] m_dout;
  logic              m_valid;
  logic              m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int c;
    c = m_store.size();
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".full"},  32'(bus.fifo_full),    32'(c == DEPTH));
    check({tag, ".empty"}, 32'(bus.fifo_empty),   32'(c == 0));
    check({tag, ".af"},    32'(bus.almost_full),  32'(c >= 3));
    check({tag, ".ae"},    32'(bus.almost_empty), 32'(c <= 1));
    check({tag, ".err"},   32'(bus.fifo_error),   32'(m_err));
    check({tag, ".valid"}, 32'(bus.valid_out),    32'(m_valid));
    check({tag, ".dout"},  32'(bus.dataout),      32'(m_dout));
  endtask

  // Called at posedge+1: drive, take the edge, update the model, compare.
  task automatic step(input bit psh, input bit pp, input logic [DATA_W-1:0] d);
    bit pop_acc, push_acc;
    bus.push   = psh;
    bus.pop    = pp;
    bus.datain = d;
    @(posedge clk);
    pop_acc  = pp && (m_store.size() > 0);
    push_acc = psh && ((m_store.size() < DEPTH) || pop_acc);
    if ((psh && !push_acc) || (pp && m_store.size() == 0)) m_err = 1'b1;
    if (pop_acc) exp_q.push_back(m_store.pop_front());
    if (push_acc) m_store.push_back(d);
    m_valid = pop_acc;
    #1;
    if (bus.valid_out) begin
      if (exp_q.size() == 0) begin
        check("sb.unexpected", 32'(bus.dataout), 32'hxx);
      end else begin
        m_dout = exp_q.pop_front();
        check("sb.data", 32'(bus.dataout), 32'(m_dout));
      end
    end
    check_state("step");
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset_L  = 1'b0;
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    bus.datain = 8'hEE;
    @(posedge clk);
    m_store.delete();
    exp_q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    #1;
    reset_L  = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check_state("rst");
  endtask

  initial begin
    reset_L    = 1'b0;
    bus.push   = 1'b0;
    bus.pop    = 1'b0;
    bus.datain = '0;
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("rst.empty_flag", 32'(bus.fifo_empty), 32'd1);
    check("rst.ae_flag",    32'(bus.almost_empty), 32'd1);

    // Three pushes reach the almost-full threshold.
    step(1, 0, 8'hA1); step(1, 0, 8'hB2); step(1, 0, 8'hC3);
    check("p3.count", 32'(bus.count), 32'd3);
    check("p3.af",    32'(bus.almost_full), 32'd1);
    check("p3.err",   32'(bus.fifo_error), 32'd0);
    repeat (3) step(0, 1, '0);
    step(0, 0, '0);

    // Fill and drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h11 + i));
    check("fill.full", 32'(bus.fifo_full), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    check("drain.empty", 32'(bus.fifo_empty), 32'd1);
    step(0, 0, '0);

    // Overflow drops the word and sets the sticky error.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h20 + i));
    step(1, 0, 8'h55);
    check("ovf.err", 32'(bus.fifo_error), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    step(0, 0, '0);

    // Push with pop on full keeps count at DEPTH without error.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h30 + i));
    step(1, 1, 8'h66);
    check("fullpp.count", 32'(bus.count), 32'd4);
    check("fullpp.err",   32'(bus.fifo_error), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    step(0, 0, '0);

    // Underflow, then reset clears the error.
    do_reset();
    step(0, 1, '0);
    check("udf.valid", 32'(bus.valid_out), 32'd0);
    check("udf.err",   32'(bus.fifo_error), 32'd1);
    do_reset();
    check("udf_rst.err", 32'(bus.fifo_error), 32'd0);

    // Push with pop on empty: no bypass, push taken, error set.
    step(1, 1, 8'h77);
    check("emptypp.count", 32'(bus.count), 32'd1);
    step(0, 1, '0);
    step(0, 0, '0);

    // Mid-stream reset discards stored words.
    do_reset();
    step(1, 0, 8'h81); step(1, 0, 8'h82);
    do_reset();
    step(0, 1, '0);

    // Pointer wrap with push/pop pairs.
    do_reset();
    step(1, 0, 8'h90);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(8'h91 + i));
      check("wrap.cnt_le", 32'(bus.count <= DEPTH), 32'd1);
    end
    step(0, 1, '0);
    step(0, 0, '0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    step(0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_dest.md
FIFO_DEST -- requirements
Module: fifo_dest

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits; SHALL match the 8-bit destination demux outputs.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two, minimum 2.
REQ-003 Parameter AF_THR, default 3, almost_full asserts when count >= AF_THR.
REQ-004 Parameter AE_THR, default 1, almost_empty asserts when count <= AE_THR.
REQ-005 One clock; reset is synchronous and active-low; ports are named clk and reset_L.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset_L  input  1  synchronous active-low reset.
REQ-008 datain  input  DATA_W  word from one destination output of the upstream destination demux.
REQ-009 push  input  1  write strobe; datain is written on a rising edge with push=1.
REQ-010 pop  input  1  read strobe from the downstream consumer.
REQ-011 dataout  output  DATA_W  registered read data.
REQ-012 valid_out  output  1  dataout holds a freshly popped word this cycle.
REQ-013 fifo_full / fifo_empty  output  1 each  occupancy flags.
REQ-014 almost_full / almost_empty  output  1 each  threshold flags.
REQ-015 count  output  log2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-016 fifo_error  output  1  sticky overflow/underflow flag.

Function
REQ-017 Storage SHALL be a circular buffer with write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits; both wrap from DEPTH-1 to 0.
REQ-018 A push is accepted when push=1 and (count<DEPTH, or pop=1 with count>0); the word is written at wr_ptr and wr_ptr increments.
REQ-019 A pop is accepted when pop=1 and count>0; the word at rd_ptr is registered to dataout, valid_out=1 on the next cycle, and rd_ptr increments.
REQ-020 Read latency: data popped at edge N appears on dataout, with valid_out=1, during the cycle after edge N; valid_out=0 in any cycle following an edge with no accepted pop.
REQ-021 dataout SHALL hold its last value when no pop is accepted.
REQ-022 count: +1 on push only, -1 on pop only, unchanged on simultaneous accepted push and pop.
REQ-023 Push with pop on a full FIFO: both accepted, count stays DEPTH, no error.
REQ-024 Push with pop on an empty FIFO: push accepted, pop rejected (no bypass), count becomes 1, fifo_error set.
REQ-025 Push on a full FIFO without pop: word dropped, storage and pointers unchanged, fifo_error set.
REQ-026 Pop on an empty FIFO: pointers unchanged, valid_out=0 next cycle, fifo_error set.
REQ-027 fifo_full = (count==DEPTH); fifo_empty = (count==0); almost_full and almost_empty are derived combinationally from the registered count.
REQ-028 fifo_error SHALL remain 1 until reset.

Reset
REQ-029 While reset_L=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, dataout=0, valid_out=0, fifo_error=0; push and pop are ignored.
REQ-030 After reset: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
REQ-031 Reset asserted mid-stream SHALL discard all stored words; storage array contents need not be cleared.

Verification
REQ-032 Reset, then push 0xA1, 0xB2, 0xC3 on consecutive cycles -> count=3, almost_full=1, fifo_empty=0, fifo_error=0.
REQ-033 Push 0x11..0x14 (4 words), then pop 4 times -> dataout 0x11, 0x12, 0x13, 0x14, each with valid_out=1 one cycle after its pop; fifo_full=1 after the 4th push; fifo_empty=1 after the 4th pop.
REQ-034 Fill with 4 words, push 0x55 without pop -> count stays 4, fifo_error=1, subsequent pops return the original 4 words with no 0x55.
REQ-035 Fill with 4 words, then push 0x66 with pop in the same cycle -> count stays 4, first word popped, 0x66 returned as the 4th subsequent pop, fifo_error=0.
REQ-036 Reset, then pop with an empty FIFO -> valid_out=0, fifo_error=1; then drive reset_L=0 for one edge -> fifo_error=0, count=0.
REQ-037 Run 10 push/pop pairs to wrap both pointers at least twice -> data order preserved, count never exceeds DEPTH.
